// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit.
package mdu_pkg;

    // RISC-V M-extension operations in funct3 order.
    typedef enum logic [2:0] {
        MDU_MUL    = 3'd0,
        MDU_MULH   = 3'd1,
        MDU_MULHSU = 3'd2,
        MDU_MULHU  = 3'd3,
        MDU_DIV    = 3'd4,
        MDU_DIVU   = 3'd5,
        MDU_REM    = 3'd6,
        MDU_REMU   = 3'd7
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } mdu_state_t;

endpackage

// File: rtl/mdu.sv
// Iterative RISC-V M-extension multiply/divide unit: shift-add multiply and
// restoring divide on unsigned magnitudes, sign fixup afterwards.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned UNROLL = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            input_ready_o,
    input  logic            input_valid_i,
    input  logic [XLEN-1:0] operand1_i,
    input  logic [XLEN-1:0] operand2_i,
    input  logic [2:0]      op_i,
    input  logic            reg_write_i,
    input  logic [4:0]      reg_addr_i,
    input  logic            flush_i,
    input  logic            output_ready_i,
    output logic            output_valid_o,
    output logic [XLEN-1:0] result_o,
    output logic            reg_write_o,
    output logic [4:0]      reg_addr_o,
    output logic            busy_o
);

    localparam int unsigned CNT_W = $clog2(XLEN + 1);
    localparam int unsigned ITERS = XLEN / UNROLL;
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

    mdu_state_t        state_q;
    mdu_op_t           op_q;
    logic              sign1_q;
    logic              sign2_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q;
    logic [XLEN-1:0]   opb_q;
    logic [XLEN-1:0]   result_q;
    logic              valid_q;
    logic              ready_q;
    logic              reg_write_q;
    logic [4:0]        reg_addr_q;

    // Operand signedness and magnitudes of the incoming operation.
    mdu_op_t         op_in;
    logic            sgn1_en;
    logic            sgn2_en;
    logic            sign1_in;
    logic            sign2_in;
    logic [XLEN-1:0] mag1_in;
    logic [XLEN-1:0] mag2_in;

    always_comb begin
        op_in   = mdu_op_t'(op_i);
        sgn1_en = 1'b0;
        sgn2_en = 1'b0;
        case (op_in)
            MDU_MUL, MDU_MULH, MDU_DIV, MDU_REM: begin
                sgn1_en = 1'b1;
                sgn2_en = 1'b1;
            end
            MDU_MULHSU: sgn1_en = 1'b1;
            default: ;
        endcase
        sign1_in = sgn1_en & operand1_i[XLEN-1];
        sign2_in = sgn2_en & operand2_i[XLEN-1];
        mag1_in  = cond_neg(operand1_i, sign1_in);
        mag2_in  = cond_neg(operand2_i, sign2_in);
    end

    // Division corner cases resolved at accept time without iterating.
    logic            is_div_in;
    logic            div_zero;
    logic            div_ovf;
    logic            special;
    logic [XLEN-1:0] special_res;

    always_comb begin
        is_div_in   = op_i[2];
        div_zero    = (operand2_i == '0);
        div_ovf     = ~op_i[0] & (operand1_i == MOST_NEG) & (operand2_i == '1);
        special     = is_div_in & (div_zero | div_ovf);
        special_res = '0;
        if (div_zero) begin
            special_res = op_i[1] ? operand1_i : '1;
        end else if (div_ovf) begin
            special_res = op_i[1] ? '0 : MOST_NEG;
        end
    end

    // UNROLL iterations of shift-add (multiply) or shift-subtract (divide).
    logic [2*XLEN-1:0] acc_d;
    logic [XLEN:0]     part;
    logic              qbit;

    always_comb begin
        acc_d = acc_q;
        part  = '0;
        qbit  = 1'b0;
        for (int unsigned i = 0; i < UNROLL; i++) begin
            if (op_q[2]) begin
                part = {acc_d[2*XLEN-1:XLEN], acc_d[XLEN-1]};
                qbit = (part >= {1'b0, opb_q});
                if (qbit) begin
                    part = part - {1'b0, opb_q};
                end
                acc_d = {part[XLEN-1:0], acc_d[XLEN-2:0], qbit};
            end else begin
                part  = {1'b0, acc_d[2*XLEN-1:XLEN]} + (acc_d[0] ? {1'b0, opb_q} : '0);
                acc_d = {part, acc_d[XLEN-1:1]};
            end
        end
    end

    // Sign correction of the unsigned result; unsigned ops carry zero signs.
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   fixup_res;

    always_comb begin
        prod      = (sign1_q ^ sign2_q) ? -acc_q : acc_q;
        fixup_res = '0;
        case (op_q)
            MDU_MUL:                      fixup_res = prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU,
            MDU_MULHU:                    fixup_res = prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:            fixup_res = cond_neg(acc_q[XLEN-1:0], sign1_q ^ sign2_q);
            MDU_REM, MDU_REMU:            fixup_res = cond_neg(acc_q[2*XLEN-1:XLEN], sign1_q);
            default:                      fixup_res = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            op_q        <= MDU_MUL;
            sign1_q     <= 1'b0;
            sign2_q     <= 1'b0;
            cnt_q       <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            ready_q     <= 1'b1;
            reg_write_q <= 1'b0;
            reg_addr_q  <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (input_valid_i && ready_q) begin
                        op_q        <= op_in;
                        sign1_q     <= sign1_in;
                        sign2_q     <= sign2_in;
                        reg_write_q <= reg_write_i;
                        reg_addr_q  <= reg_addr_i;
                        ready_q     <= 1'b0;
                        if (special) begin
                            result_q <= special_res;
                            valid_q  <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            // Multiplier (or dividend) sits in the low half and shifts out.
                            acc_q   <= {{XLEN{1'b0}}, is_div_in ? mag1_in : mag2_in};
                            opb_q   <= is_div_in ? mag2_in : mag1_in;
                            cnt_q   <= CNT_W'(ITERS);
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= FIXUP;
                    end
                end
                FIXUP: begin
                    result_q <= fixup_res;
                    valid_q  <= 1'b1;
                    state_q  <= DONE;
                end
                DONE: begin
                    if (output_ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign input_ready_o  = ready_q;
    assign output_valid_o = valid_q;
    assign result_o       = result_q;
    assign reg_write_o    = reg_write_q;
    assign reg_addr_o     = reg_addr_q;
    assign busy_o         = (state_q != IDLE);

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: a UNROLL=1 and a UNROLL=4 instance share stimulus and are
// compared against an arithmetic reference of the M-extension semantics.
module tb_mdu;
    import mdu_pkg::*;

    localparam logic [31:0] MNEG = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] opa = '0;
    logic [31:0] opb = '0;
    logic [2:0]  op = '0;
    logic        rw_in = 1'b0;
    logic [4:0]  ra_in = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b1;

    logic        rdy1, ov1, rw1, busy1;
    logic [31:0] res1;
    logic [4:0]  ra1;
    logic        rdy4, ov4, rw4, busy4;
    logic [31:0] res4;
    logic [4:0]  ra4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mdu #(.XLEN(32), .UNROLL(1)) u1 (
        .clk_i(clk), .rst_i(rst_i), .input_ready_o(rdy1), .input_valid_i(in_valid),
        .operand1_i(opa), .operand2_i(opb), .op_i(op), .reg_write_i(rw_in),
        .reg_addr_i(ra_in), .flush_i(flush), .output_ready_i(out_ready),
        .output_valid_o(ov1), .result_o(res1), .reg_write_o(rw1), .reg_addr_o(ra1),
        .busy_o(busy1)
    );

    mdu #(.XLEN(32), .UNROLL(4)) u4 (
        .clk_i(clk), .rst_i(rst_i), .input_ready_o(rdy4), .input_valid_i(in_valid),
        .operand1_i(opa), .operand2_i(opb), .op_i(op), .reg_write_i(rw_in),
        .reg_addr_i(ra_in), .flush_i(flush), .output_ready_i(out_ready),
        .output_valid_o(ov4), .result_o(res4), .reg_write_o(rw4), .reg_addr_o(ra4),
        .busy_o(busy4)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference semantics from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      ub;
        logic [63:0] ua64;
        logic [63:0] ub64;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sb   = longint'($signed(b));
        ub   = longint'(b);
        ua64 = {32'b0, a};
        ub64 = {32'b0, b};
        p    = '0;
        case (o)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua64 * ub64; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MNEG && b == 32'hFFFF_FFFF) return MNEG;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (a == MNEG && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return MNEG;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // One handshake-complete operation on both instances; starts/ends at posedge+1.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        logic        rw;
        logic [4:0]  ra;
        logic        spec;
        logic        got1, got4;
        int          lat1, lat4;
        logic [31:0] r1, r4;
        logic [4:0]  a1, a4;
        logic        w1, w4;
        rw   = 1'($urandom_range(0, 1));
        ra   = 5'($urandom);
        spec = o[2] && (b == 0 || (!o[0] && a == MNEG && b == 32'hFFFF_FFFF));
        got1 = 1'b0; got4 = 1'b0; lat1 = 0; lat4 = 0;
        r1 = '0; r4 = '0; a1 = '0; a4 = '0; w1 = 1'b0; w4 = 1'b0;
        chk({tag, "_idle_rdy"}, {62'b0, rdy1, rdy4}, 64'd3);
        op = o; opa = a; opb = b; rw_in = rw; ra_in = ra;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_busy"}, {60'b0, rdy1, rdy4, busy1, busy4}, 64'd3);
        for (int c = 1; c <= 60 && !(got1 && got4); c++) begin
            if (!got1 && ov1) begin got1 = 1'b1; lat1 = c; r1 = res1; a1 = ra1; w1 = rw1; end
            if (!got4 && ov4) begin got4 = 1'b1; lat4 = c; r4 = res4; a4 = ra4; w4 = rw4; end
            if (!(got1 && got4)) begin @(posedge clk); #1; end
        end
        chk({tag, "_done"}, {62'b0, got1, got4}, 64'd3);
        chk({tag, "_res_u1"}, 64'(r1), 64'(exp));
        chk({tag, "_res_u4"}, 64'(r4), 64'(exp));
        chk({tag, "_lat_u1"}, 64'(lat1), spec ? 64'd1 : 64'd34);
        chk({tag, "_lat_u4"}, 64'(lat4), spec ? 64'd1 : 64'd10);
        chk({tag, "_wb"}, {50'b0, w1, a1, w4, a4}, {50'b0, rw, ra, rw, ra});
        @(posedge clk); #1;
    endtask

    initial begin
        logic [31:0] snap1, snap4;
        int          bad;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", {60'b0, rdy1, ov1, busy1, rw1}, 64'h8);
        chk("reset_ctl4", {60'b0, rdy4, ov4, busy4, rw4}, 64'h8);
        chk("reset_data", {res1, 22'b0, ra1, ra4}, 64'd0);
        chk("reset_res4", 64'(res4), 64'd0);
        @(negedge clk); rst_i = 1'b1;
        @(posedge clk); #1;

        // Directed operations.
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7x-3");
        run_op(3'd1, MNEG, MNEG, 32'h4000_0000, "mulh_mneg");
        run_op(3'd3, MNEG, MNEG, 32'h4000_0000, "mulhu_mneg");
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_m1");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_-7_2");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_-7_2");
        run_op(3'd7, 32'd7, 32'd2, 32'd1, "remu_7_2");
        run_op(3'd4, 32'd1234, 32'd0, 32'hFFFF_FFFF, "div_by0");
        run_op(3'd5, 32'd99, 32'd0, 32'hFFFF_FFFF, "divu_by0");
        run_op(3'd6, 32'd5, 32'd0, 32'd5, "rem_by0");
        run_op(3'd4, MNEG, 32'hFFFF_FFFF, MNEG, "div_ovf");
        run_op(3'd6, MNEG, 32'hFFFF_FFFF, 32'd0, "rem_ovf");

        // Downstream stall holds outputs.
        op = 3'd0; opa = 32'd123; opb = 32'd456; rw_in = 1'b1; ra_in = 5'd17;
        out_ready = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        snap1 = res1; snap4 = res4;
        chk("stall_res", {snap1, snap4}, {32'd56088, 32'd56088});
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!ov1 || !ov4 || rdy1 || rdy4 || res1 != 32'd56088 || res4 != 32'd56088
                || ra1 != 5'd17 || ra4 != 5'd17 || !rw1 || !rw4) bad++;
            @(posedge clk); #1;
        end
        chk("stall_hold", 64'(bad), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall_release", {60'b0, ov1, ov4, rdy1, rdy4}, 64'h3);

        // Flush while idle blocks acceptance.
        op = 3'd0; opa = 32'd3; opb = 32'd3; flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_idle", {60'b0, rdy1, rdy4, busy1, busy4}, 64'hC);

        // Flush mid-CALC aborts with no output.
        op = 3'd5; opa = 32'd1000; opb = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_calc", {60'b0, ov1, ov4, rdy1, rdy4}, 64'h3);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (ov1 || ov4) bad++;
            @(posedge clk); #1;
        end
        chk("flush_novalid", 64'(bad), 64'd0);

        // Asynchronous reset mid-CALC.
        op = 3'd1; opa = 32'd55; opb = 32'd66; rw_in = 1'b1; ra_in = 5'd9; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_i = 1'b0;
        #1;
        chk("arst_ctl", {56'b0, rdy1, ov1, busy1, rw1, rdy4, ov4, busy4, rw4}, 64'h88);
        chk("arst_data", {res1, res4}, 64'd0);
        chk("arst_addr", {54'b0, ra1, ra4}, 64'd0);
        @(negedge clk); rst_i = 1'b1;
        @(posedge clk); #1;

        // Randomised operations against the reference.
        for (int i = 0; i < 1000; i++) begin
            logic [2:0]  ro;
            logic [31:0] ra, rb;
            ro = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            run_op(ro, ra, rb, ref_result(ro, ra, rb), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

- Iterative, parametrised multiply/divide unit implementing the RISC-V M-extension operations.
- Sits beside the execute stage: takes decoded operands through a valid/ready handshake and holds the pipeline while busy.
- Delivers the result plus write-back pass-through through a second valid/ready handshake.
- Adds configurable datapath width, configurable bits-per-cycle throughput, multi-cycle operation and flush abort.

## Interface
- XLEN, 32, datapath width; even, ≥ 8.
- UNROLL, 1, bits retired per iteration; one of 1, 2, 4; must divide XLEN.
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous and active-low.
- input_ready_o  out  1  unit idle, can accept.
- input_valid_i  in  1  operation present.
- operand1_i  in  XLEN  rs1 value (multiplicand / dividend).
- operand2_i  in  XLEN  rs2 value (multiplier / divisor).
- op_i  in  3  operation: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (funct3 order 0..7).
- reg_write_i  in  1  write-back enable pass-through.
- reg_addr_i  in  5  destination register pass-through.
- flush_i  in  1  abort current operation.
- output_ready_i  in  1  downstream accepts.
- output_valid_o  out  1  result valid.
- result_o  out  XLEN  result.
- reg_write_o  out  1  registered reg_write_i.
- reg_addr_o  out  5  registered reg_addr_i.
- busy_o  out  1  state ≠ IDLE.

## Operation
- **FSM states:** IDLE, CALC, FIXUP, DONE.
- **IDLE**
  - input_ready_o = 1.
  - On accept (input_valid_i & input_ready_o & ~flush_i): latch op, pass-throughs, operand signs and unsigned magnitudes.
  - Normal operation → CALC with iteration counter = XLEN/UNROLL.
  - Special case → DONE directly with result preloaded.
- **Magnitudes**
  - Signed operand: two's-complement negation if negative; XLEN-bit unsigned (most-negative maps to 2^(XLEN-1)).
  - MULHSU: operand1 signed, operand2 unsigned.
  - MULHU/DIVU/REMU: both unsigned.
- **CALC**
  - Multiply: shift-add on a 2·XLEN accumulator, UNROLL multiplier bits per cycle.
  - Divide: restoring shift-subtract, UNROLL quotient bits per cycle.
  - Counter decrements each cycle; at 1 → FIXUP.
- **FIXUP** (one cycle), then → DONE:
  - MUL: result = low XLEN bits of the product.
  - MULH/MULHSU/MULHU: result = high XLEN bits, product negated over 2·XLEN first when sign1 ^ sign2 (signed variants).
  - DIV: quotient negated if sign1 ^ sign2.
  - REM: remainder negated if sign1.
- **DONE**
  - output_valid_o = 1; result_o, reg_write_o, reg_addr_o stable.
  - Leaves to IDLE on output_ready_i.
- **Special cases** (bypass CALC):
  - Divisor 0, DIV/DIVU: result = all ones.
  - Divisor 0, REM/REMU: result = operand1.
  - DIV with operand1 = most-negative and operand2 = −1: result = most-negative.
  - REM with operand1 = most-negative and operand2 = −1: result = 0.
- **flush_i**
  - From any state → IDLE next cycle; output_valid_o = 0 next cycle.
  - Flush in IDLE blocks acceptance that cycle.
  - Flush wins over output_ready_i.

## Timing
- **Reset:** state IDLE.
  - input_ready_o = 1, busy_o = 0, output_valid_o = 0.
  - result_o, reg_write_o, reg_addr_o = 0.
  - Accumulators and counter = 0.
  - Reset mid-operation discards the operation with no output.
- **Latency**
  - Accept edge to output_valid_o high: XLEN/UNROLL + 2 cycles (34 for defaults, 10 for XLEN=32, UNROLL=4).
  - Special case: 1 cycle.
- input_ready_o is low from the cycle after accept until the cycle after DONE handshakes.
- **Throughput:** one operation per latency + 1 cycles with output_ready_i held high; no back-to-back acceptance in the same cycle as the DONE handshake.
- output_valid_o and data are registered outputs; no combinational path from any input.
- Downstream stall in DONE holds all outputs indefinitely.

## Structure
- ecap5_dproc_pkg gains mdu_op_t (3-bit, MDU_MUL=0 … MDU_REMU=7) and mdu_state_t (IDLE, CALC, FIXUP, DONE).
- Single module; no sub-module required.
- Signed/unsigned magnitude and negate logic is a local function.

## Test plan
- **MUL:** XLEN=32, op MUL, 7 × −3, output_ready_i=1 → result 0xFFFFFFEB after 34 cycles, reg_addr_o matches input.
- **MULH/MULHU:** 0x80000000 × 0x80000000 → MULH 0x40000000; same operands with MULHU → 0x40000000; MULHSU(−1, 0xFFFFFFFF) → 0xFFFFFFFF.
- **Signed divide:** DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; REMU 7/2 → 1; each 34 cycles.
- **Special cases:** DIV x/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/−1 → 0x80000000; REM 0x80000000/−1 → 0; each valid 1 cycle after accept.
- **Stall and flush:** hold output_ready_i=0 ten cycles in DONE → outputs stable, input_ready_o=0. Assert flush_i mid-CALC → output_valid_o never rises, input_ready_o=1 next cycle.
- **UNROLL=4:** randomised 1000 ops checked against a reference model; latency 10. Async reset pulse mid-CALC → all outputs zero immediately, input_ready_o=1.
